// File: rtl/vector_point_reader.sv
// vector_point_reader: walks the point RAM on go and drives the X/Y DACs, ending each frame with a halt pulse.
// Ports: clk, rst (async, active-low), go; addr/data_in RAM read port (one-cycle latency);
// halt/busy frame handshake; x_ch/y_ch DAC coordinates; blank beam-off.
// Build option VECTOR_SLEW_EN: draw points step one unit per cycle per axis; undefined, they jump.
module vector_point_reader #(
  parameter int ADDRESSWIDTH = 16,
  parameter int DATAWIDTH = 18,
  parameter int OUT_WIDTH = 8,
  parameter int DEPTH = 1000,
  parameter int DWELL_CYCLES = 4,
  parameter int CEASE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  output logic [ADDRESSWIDTH-1:0] addr,
  input  logic [DATAWIDTH-1:0] data_in,
  output logic halt,
  output logic busy,
  output logic [OUT_WIDTH-1:0] x_ch,
  output logic [OUT_WIDTH-1:0] y_ch,
  output logic blank
);
  localparam int CW = $clog2((DWELL_CYCLES > CEASE_CYCLES ? DWELL_CYCLES : CEASE_CYCLES) + 1);
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
`ifdef VECTOR_SLEW_EN
    SLEW,
`endif
    DWELL,
    CEASE,
    DONE
  } state_t;
  state_t state, next_state;
  logic [CW-1:0] cnt, cnt_nx;
  logic [ADDRESSWIDTH-1:0] addr_nx;
  logic [OUT_WIDTH-1:0] x_nx, y_nx, w_x, w_y;
  logic w_eof, w_move, at_last, last_pt, last_pt_nx, blank_nx, show;
  assign w_eof = data_in[DATAWIDTH-1];
  assign w_move = data_in[DATAWIDTH-2];
  assign w_x = data_in[2*OUT_WIDTH-1:OUT_WIDTH];
  assign w_y = data_in[OUT_WIDTH-1:0];
  assign at_last = addr == ADDRESSWIDTH'(DEPTH - 1);
`ifdef VECTOR_SLEW_EN
  logic [OUT_WIDTH-1:0] tx, ty, x_step, y_step;
  // magnitude compare so the step never wraps around the coordinate range
  assign x_step = x_ch < tx ? x_ch + 1'b1 : x_ch > tx ? x_ch - 1'b1 : x_ch;
  assign y_step = y_ch < ty ? y_ch + 1'b1 : y_ch > ty ? y_ch - 1'b1 : y_ch;
  assign show = state == LOAD && !w_eof && w_move;
`else
  assign show = state == LOAD && !w_eof;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  next_state = go ? FETCH : IDLE;
      FETCH: next_state = LOAD;
`ifdef VECTOR_SLEW_EN
      LOAD:  next_state = w_eof ? CEASE : w_move ? DWELL : SLEW;
      // compare the stepped position so the arrival cycle itself is the last slew cycle
      SLEW:  next_state = (x_step == tx && y_step == ty) ? DWELL : SLEW;
`else
      LOAD:  next_state = w_eof ? CEASE : DWELL;
`endif
      // last_pt forces end-of-frame after the final RAM word instead of wrapping
      DWELL: next_state = cnt == CW'(DWELL_CYCLES - 1) ? (last_pt ? CEASE : FETCH) : DWELL;
      CEASE: next_state = cnt == CW'(CEASE_CYCLES - 1) ? DONE : CEASE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    addr_nx = next_state == IDLE ? '0 : (state == LOAD && !w_eof && !at_last) ? addr + 1'b1 : addr;
    last_pt_nx = state == LOAD ? at_last : last_pt;
    cnt_nx = (next_state == state && (state == DWELL || state == CEASE)) ? cnt + 1'b1 : '0;
    blank_nx = (next_state == IDLE || next_state == CEASE || next_state == DONE) ? 1'b1 : state == LOAD ? w_move : blank;
`ifdef VECTOR_SLEW_EN
    x_nx = show ? w_x : state == SLEW ? x_step : x_ch;
    y_nx = show ? w_y : state == SLEW ? y_step : y_ch;
`else
    x_nx = show ? w_x : x_ch;
    y_nx = show ? w_y : y_ch;
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
      x_ch <= '0;
      y_ch <= '0;
      blank <= 1'b1;
      halt <= 1'b0;
      busy <= 1'b0;
      cnt <= '0;
      last_pt <= 1'b0;
`ifdef VECTOR_SLEW_EN
      tx <= '0;
      ty <= '0;
`endif
    end else begin
      addr <= addr_nx;
      x_ch <= x_nx;
      y_ch <= y_nx;
      blank <= blank_nx;
      halt <= next_state == DONE;
      busy <= next_state != IDLE;
      cnt <= cnt_nx;
      last_pt <= last_pt_nx;
`ifdef VECTOR_SLEW_EN
      if (state == LOAD) begin
        tx <= w_x;
        ty <= w_y;
      end
`endif
    end
  end
endmodule

// File: tb/tb_vector_point_reader.sv
// tb_vector_point_reader: directed checks of the vector point reader against hand-computed frames.
module tb_vector_point_reader;
  logic clk = 1'b0, rst = 1'b0, go = 1'b0, halt, busy, blank;
  logic [15:0] addr;
  logic [17:0] data_in = '0;
  logic [7:0] x_ch, y_ch;
  logic [17:0] ram [0:999];
  logic [15:0] slew_exp [0:2] = '{16'h0B13, 16'h0C12, 16'h0D12};
  int checks = 0, errors = 0;
  int hat, hcnt, amax, bad;
`ifdef VECTOR_SLEW_EN
  localparam int FRAME = 34;
`else
  localparam int FRAME = 31;
`endif
  vector_point_reader dut (
    .clk(clk), .rst(rst), .go(go), .addr(addr), .data_in(data_in),
    .halt(halt), .busy(busy), .x_ch(x_ch), .y_ch(y_ch), .blank(blank)
  );
  always #5 clk = ~clk;
  always @(posedge clk) data_in <= ram[addr];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic go_pulse();
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
  endtask
  function automatic logic [17:0] mv(input logic [7:0] x, input logic [7:0] y);
    return {2'b01, x, y};
  endfunction
  function automatic logic [17:0] dr(input logic [7:0] x, input logic [7:0] y);
    return {2'b00, x, y};
  endfunction
  task automatic load_basic();
    ram[0] = mv(8'd10, 8'd20);
    ram[1] = dr(8'd13, 8'd18);
    ram[2] = 18'h20000;
  endtask
  task automatic basic_frame();
    go_pulse();
    check("busy_fetch", busy, 1);
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("move_xy", {x_ch, y_ch}, 16'h0A14);
      check("move_blank", blank, 1);
    end
    step();
    step();
    check("addr_one", addr, 1);
    check("pre_draw_xy", {x_ch, y_ch}, 16'h0A14);
`ifdef VECTOR_SLEW_EN
    for (int i = 0; i < 3; i++) begin
      step();
      check("slew_xy", {x_ch, y_ch}, slew_exp[i]);
      check("slew_blank", blank, 0);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      step();
      check("draw_xy", {x_ch, y_ch}, 16'h0D12);
      check("draw_blank", blank, 0);
    end
    step();
    step();
    for (int i = 0; i < 16; i++) begin
      step();
      check("cease_blank", blank, 1);
      check("cease_xy", {x_ch, y_ch}, 16'h0D12);
      check("cease_halt", halt, 0);
    end
    step();
    check("done_halt", halt, 1);
    check("done_busy", busy, 1);
    step();
    check("idle_halt", halt, 0);
    check("idle_busy", busy, 0);
    check("idle_addr", addr, 0);
  endtask
  task automatic run(input int len, input int a, input int b, output int h_at, output int h_cnt, output int a_max);
    h_at = 0;
    h_cnt = 0;
    a_max = 0;
    go_pulse();
    for (int i = 1; i <= len; i++) begin
      if (halt === 1'b1) begin
        h_cnt++;
        h_at = i;
      end
      if (int'(addr) > a_max) a_max = int'(addr);
      go = (i == a || i == b);
      step();
    end
    go = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 1000; i++) ram[i] = '0;
    load_basic();
    repeat (2) step();
    check("rst_addr", addr, 0);
    check("rst_xy", {x_ch, y_ch}, 0);
    check("rst_blank", blank, 1);
    check("rst_halt", halt, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    step();
    basic_frame();
    ram[0] = 18'h20000;
    go_pulse();
    hcnt = 0;
    hat = 0;
    bad = 0;
    for (int i = 1; i <= 40; i++) begin
      if (halt === 1'b1) begin
        hcnt++;
        hat = i;
      end
      if (addr !== 16'd0 || {x_ch, y_ch} !== 16'h0D12) bad = 1;
      step();
    end
    check("empty_halt_at", hat, 19);
    check("empty_halt_cnt", hcnt, 1);
    check("empty_hold", bad, 0);
    load_basic();
    run(45, 9, FRAME, hat, hcnt, amax);
    check("busygo_halt_at", hat, FRAME);
    check("busygo_halt_cnt", hcnt, 1);
    check("busygo_idle", busy, 0);
    go_pulse();
    repeat (8) step();
    rst = 1'b0;
    #1;
    check("midrst_xy", {x_ch, y_ch}, 0);
    check("midrst_blank", blank, 1);
    check("midrst_busy", busy, 0);
    check("midrst_halt", halt, 0);
    check("midrst_addr", addr, 0);
    step();
    rst = 1'b1;
    basic_frame();
    for (int i = 0; i < 1000; i++) ram[i] = mv(8'(i), 8'(i >> 2));
    run(6030, 0, 0, hat, hcnt, amax);
    check("ovf_halt_at", hat, 6017);
    check("ovf_halt_cnt", hcnt, 1);
    check("ovf_addr_max", amax, 999);
    check("ovf_last_xy", {x_ch, y_ch}, {8'd231, 8'd249});
    check("ovf_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
